// File: rtl/kf8255_handshake.sv
// Mode 1/2 STB#/ACK# handshake controller for one 8255 port group.
// Synchronises the strobe pins and maintains IBF, OBF#, INTR and INTE.
module kf8255_handshake #(
   parameter int GROUP_A     = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] mode_select_reg,
   input  logic       port_io_reg,
   input  logic       update_mode,
   input  logic       read_start,
   input  logic       read_end,
   input  logic       write_start,
   input  logic       write_end,
   input  logic       inte_write,
   input  logic       inte_sel,
   input  logic       inte_value,
   input  logic       stb_n,
   input  logic       ack_n,
   output logic       strobe,
   output logic       hiz,
   output logic       ibf,
   output logic       obf_n,
   output logic       intr,
   output logic       inte1,
   output logic       inte2
);
   localparam int S = SYNC_STAGES;

   logic         clr;
   logic [S-1:0] stb_sync, ack_sync;
   logic         stb_dly, ack_dly;
   logic         stb_fall, stb_rise, ack_fall, ack_rise;
   logic         mode0, mode2, in_side, out_side;
   logic         in_set, out_set;
   logic         strobe_d, hiz_d, ibf_d, obf_n_d, intr_d, inte1_d, inte2_d;

   assign clr = reset || update_mode;

   // Synchroniser chains; the delayed copy of the last stage feeds the edge detectors.
   always_ff @(posedge clock) begin
      if (clr) begin
         stb_sync <= '1;
         ack_sync <= '1;
         stb_dly  <= 1'b1;
         ack_dly  <= 1'b1;
      end else begin
         stb_sync <= {stb_sync[S-2:0], stb_n};
         ack_sync <= {ack_sync[S-2:0], ack_n};
         stb_dly  <= stb_sync[S-1];
         ack_dly  <= ack_sync[S-1];
      end
   end

   assign stb_fall = stb_dly && !stb_sync[S-1];
   assign stb_rise = !stb_dly && stb_sync[S-1];
   assign ack_fall = ack_dly && !ack_sync[S-1];
   assign ack_rise = !ack_dly && ack_sync[S-1];

   assign mode0    = (mode_select_reg == 2'b00);
   assign mode2    = mode_select_reg[1] && (GROUP_A != 0);
   assign in_side  = mode2 || (!mode0 && !mode2 && port_io_reg);
   assign out_side = mode2 || (!mode0 && !mode2 && !port_io_reg);

   // Interrupt set conditions see an INTE bit written in the same cycle.
   assign in_set  = in_side && stb_rise && ibf && inte2_d;
   assign out_set = out_side && ack_rise && obf_n && inte1_d;

   always_comb begin
      inte1_d  = inte1;
      inte2_d  = inte2;
      if (inte_write) begin
         if (inte_sel) inte2_d = inte_value;
         else          inte1_d = inte_value;
      end
   end

   always_comb begin
      strobe_d = in_side && stb_fall;
      hiz_d    = !(mode2 && !ack_sync[S-1]);
      ibf_d    = ibf;
      obf_n_d  = obf_n;
      intr_d   = intr;
      if (mode0) begin
         ibf_d   = 1'b0;
         obf_n_d = 1'b1;
         intr_d  = 1'b0;
      end else begin
         if (in_side)
            ibf_d = stb_fall || (ibf && !read_end);
         if (out_side) begin
            if (write_end)     obf_n_d = 1'b0;
            else if (ack_fall) obf_n_d = 1'b1;
         end
         if (in_set || out_set)
            intr_d = 1'b1;
         else if ((in_side && read_start) || (out_side && write_start))
            intr_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (clr) begin
         strobe <= 1'b0;
         hiz    <= 1'b1;
         ibf    <= 1'b0;
         obf_n  <= 1'b1;
         intr   <= 1'b0;
         inte1  <= 1'b0;
         inte2  <= 1'b0;
      end else begin
         strobe <= strobe_d;
         hiz    <= hiz_d;
         ibf    <= ibf_d;
         obf_n  <= obf_n_d;
         intr   <= intr_d;
         inte1  <= inte1_d;
         inte2  <= inte2_d;
      end
   end
endmodule

// File: doc/kf8255_handshake.md
# kf8255_handshake

Mode 1/2 strobe-and-handshake controller for one KF8255 port group. It sits directly upstream of a group's port register. It synchronises the external STB#/ACK# pins and generates the one-cycle `strobe` input-latch pulse and the `hiz` output-enable for that port. It also maintains the IBF, OBF# and INTR flags and the INTE enables that Port C presents to the CPU.

## Interface
- `GROUP_A`, default 1: 1 enables mode 2 (bidirectional). 0 makes mode 2 behave as mode 1.
- `SYNC_STAGES`, default 2: flop stages on `stb_n` and `ack_n`. Legal values are 2 to 3.

- `clock`  in  1: single clock. All flops update on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `mode_select_reg`  in  2: 00 = mode 0, 01 = mode 1, 1x = mode 2.
- `port_io_reg`  in  1: 1 = input, 0 = output (mode 1 direction).
- `update_mode`  in  1: one-cycle pulse when a mode-set control word is written.
- `read_start`, `read_end`  in  1 each: one-cycle pulses at the RD# falling and rising edges for this port.
- `write_start`, `write_end`  in  1 each: one-cycle pulses at the WR# falling and rising edges for this port.
- `inte_write`  in  1: one-cycle Port C bit set/reset pulse targeting an INTE bit.
- `inte_sel`  in  1: 0 = INTE1 (output side), 1 = INTE2 (input side).
- `inte_value`  in  1: value written to the selected INTE bit.
- `stb_n`, `ack_n`  in  1 each: asynchronous external pins.
- `strobe`  out  1: one-cycle pulse that tells the port to latch `port_in`.
- `hiz`  out  1: 1 = port output tri-stated. Used in mode 2 only.
- `ibf`  out  1: input buffer full.
- `obf_n`  out  1: output buffer full, active low.
- `intr`  out  1: interrupt request.
- `inte1`, `inte2`  out  1 each: interrupt enables.

## Operation
- **Reset or `update_mode`.** `strobe`=0, `hiz`=1, `ibf`=0, `obf_n`=1, `intr`=0, `inte1`=0, `inte2`=0. Synchroniser flops are loaded with 1. `update_mode` takes priority over every other event in the same cycle.
- **Edge detection.** Edges are detected on the last synchroniser stage against a one-cycle-delayed copy of it. All raw pin transitions are seen only through this path.
- **Mode 0.** All flags are held at their reset values. `strobe`=0 and `hiz`=1. Edges on the pins are ignored. INTE writes are still accepted.
- **Mode 1, input (`port_io_reg`=1).**
  - Falling edge of STB#: assert `strobe` for one cycle and set `ibf`.
  - Rising edge of STB#: set `intr` if `ibf` and `inte2` are both 1.
  - `read_start` clears `intr`. `read_end` clears `ibf`.
  - `ack_n` is ignored.
- **Mode 1, output (`port_io_reg`=0).**
  - `write_start` clears `intr`. `write_end` clears `obf_n`.
  - Falling edge of ACK#: set `obf_n` to 1.
  - Rising edge of ACK#: set `intr` if `obf_n`=1 and `inte1`=1.
  - `stb_n` is ignored and `strobe` stays 0.
- **Mode 2 (`GROUP_A`=1).** Both handshakes run together.
  - Input side uses the STB#/`ibf`/`inte2` rules above. Output side uses the ACK#/`obf_n`/`inte1` rules above.
  - `hiz` = 0 while synchronised ACK# is low, otherwise 1.
  - `intr` is set by either side's set condition.
  - `intr` is cleared by `read_start` or `write_start` only when no set condition fires in the same cycle.
- **Simultaneous events.**
  - Set beats clear for `ibf`: a STB# falling edge in the same cycle as `read_end` leaves `ibf`=1.
  - `write_end` beats an ACK# falling edge for `obf_n`: the result is 0.
  - An INTE write and an `intr` set condition in the same cycle use the new INTE value.
- **Repeated strobes.** A second STB# falling edge while `ibf`=1 still pulses `strobe`. The new data overwrites the old, matching 8255 behaviour.

## Timing
- A raw pin edge reaches the detector after `SYNC_STAGES` clocks.
- `strobe`, `ibf` and `intr` change on the edge after detection. Total latency is `SYNC_STAGES`+1 clocks from the first rising edge that samples the new pin level.
- `strobe` is exactly one cycle wide per detected STB# falling edge.
- CPU pulses (`read_*`, `write_*`, `inte_write`) act on the next clock edge, i.e. 1-cycle latency.
- `hiz` follows synchronised ACK# with `SYNC_STAGES`+1 latency, in both directions.
- Minimum STB#/ACK# low or high width for guaranteed detection is `SYNC_STAGES`+1 clocks. Shorter pulses are unspecified.
- Reset asserted mid-handshake returns all outputs to their reset values on the next edge. No pulse or flag survives.

## Test plan
- **Mode 1 input, `SYNC_STAGES`=2, `inte2`=1.** Drive STB# low for 4 clocks then high.
  - Expect `strobe`=1 for exactly one cycle, 3 clocks after STB# falls.
  - Expect `ibf`=1 at the same time. Expect `intr`=1 3 clocks after STB# rises.
  - Then `read_start` → `intr`=0 next cycle. Then `read_end` → `ibf`=0.
- **Mode 1 output, `inte1`=1.** Apply `write_start` then `write_end` → `intr`=0, then `obf_n`=0.
  - Pulse ACK# low for 4 clocks → `obf_n`=1 3 clocks after the fall.
  - Expect `intr`=1 3 clocks after the rise.
- **Mode 2.** Hold ACK# low for 5 clocks.
  - Expect `hiz`=0 from cycle 3 until 3 clocks after ACK# rises, then 1.
  - A concurrent STB# pulse still sets `ibf` and pulses `strobe`.
- **Priorities.** Make a STB# falling edge detection coincide with `read_end` → `ibf` stays 1.
  - Make `update_mode` coincide with the same event → `ibf`=0 and `strobe`=0.
- **INTE masking.** With `inte2`=0, complete an input handshake → `intr` stays 0.
  - Then `inte_write` with `inte_sel`=1, `inte_value`=1 → `inte2`=1, and `intr` still stays 0 until the next STB# rising edge.
- **Reset mid-op.** Assert `reset` one cycle after a STB# falling edge is detected → next cycle shows all outputs at reset values, with `strobe`=0.
  - Mode 0 with pin toggling → no flag or `strobe` activity.
